// File: rtl/crossing_pkg.sv
// Shared types and constants for the pedestrian/cyclist crossing request logic.
package crossing_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAITING  = 2'd1,
        SERVING  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // Bit positions inside the trafficlight lightseq bus
    localparam int LS_CAR_R   = 5;
    localparam int LS_CAR_A   = 4;
    localparam int LS_CAR_G   = 3;
    localparam int LS_X_RED   = 2;
    localparam int LS_X_GREEN = 1;
    localparam int LS_X_FLASH = 0;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, consecutive-sample debouncer and rising-edge press pulse
// for a raw asynchronous push-button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             btn_s;
    logic             db;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_a <= button;
            btn_s  <= sync_a;
        end
    end

    // press fires in the same edge that db takes a new high level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db    <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db    <= btn_s;
                cnt   <= '0;
                press <= btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossing_request.sv
// Crossing-side request handshake: latches a debounced press, holds start until
// crossing-green is seen, enforces a cooldown and queues one extra request.
module crossing_request
    import crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [5:0] lightseq,
    output logic       start,
    output logic       wait_lamp,
    output logic       pending,
    output logic       fault
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int CD_W = $clog2(COOLDOWN_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic            press;
    logic            green;
    logic            cd_done;
    logic [TO_W-1:0] to_cnt;
    logic [CD_W-1:0] cd_cnt;
    logic            unused_ls;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .button (button),
        .press  (press)
    );

    assign green     = lightseq[LS_X_GREEN];
    assign unused_ls = ^{lightseq[LS_CAR_R:LS_X_RED], lightseq[LS_X_FLASH]};
    assign cd_done   = (state == COOLDOWN) && (cd_cnt == CD_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (press)  state_next = WAITING;
            WAITING:  if (green)  state_next = SERVING;
            SERVING:  if (!green) state_next = COOLDOWN;
            COOLDOWN: if (cd_done) state_next = (pending || press) ? WAITING : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Timeout counter restarts on every entry to WAITING and saturates at the limit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            fault  <= 1'b0;
        end else if (state != WAITING) begin
            to_cnt <= '0;
        end else if (!green && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_MAX - 1'b1) fault <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cd_cnt  <= '0;
            pending <= 1'b0;
        end else begin
            if (state == COOLDOWN && !cd_done) cd_cnt <= cd_cnt + 1'b1;
            else                               cd_cnt <= '0;

            if (cd_done)
                pending <= 1'b0;
            else if (press && (state == SERVING || state == COOLDOWN))
                pending <= 1'b1;
        end
    end

    assign start     = (state == WAITING);
    assign wait_lamp = start | pending;

endmodule

// File: tb/tb_crossing_request.sv
// Directed bench for crossing_request; start rising edges are checked against a
// queue of expected cycle numbers.
module tb_crossing_request;

    logic       clock = 1'b0;
    logic       reset;
    logic       button;
    logic [5:0] lightseq;
    logic       start;
    logic       wait_lamp;
    logic       pending;
    logic       fault;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_q[$];
    logic start_prev = 1'b0;

    localparam logic [5:0] LS_GREEN = 6'b100010;
    localparam logic [5:0] LS_RED   = 6'b001100;

    crossing_request #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(8),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .button    (button),
        .lightseq  (lightseq),
        .start     (start),
        .wait_lamp (wait_lamp),
        .pending   (pending),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Every start rise must match the oldest expected cycle number
    always @(negedge clock) begin
        if (start && !start_prev) begin
            if (exp_q.size() == 0) check("start_rise_unexpected", exp_q.size(), 1);
            else                   check("start_rise_cycle", cyc, exp_q.pop_front());
        end
        start_prev = start;
    end

    initial begin
        reset    = 1'b0;
        button   = 1'b0;
        lightseq = LS_RED;
        step(3);
        check("rst_start", start, 0);
        check("rst_wait_lamp", wait_lamp, 0);
        check("rst_pending", pending, 0);
        check("rst_fault", fault, 0);
        reset = 1'b1;
        step(2);

        // Basic request: held button, green 10 cycles after start
        button = 1'b1;
        exp_q.push_back(cyc + 7);
        step(6);
        check("t1_start_before", start, 0);
        step(1);
        check("t1_start", start, 1);
        check("t1_wait_lamp", wait_lamp, 1);
        check("t1_pending", pending, 0);
        step(9);
        lightseq = LS_GREEN;
        check("t1_start_held", start, 1);
        step(1);
        check("t1_start_fall", start, 0);
        check("t1_wait_lamp_off", wait_lamp, 0);
        step(3);
        button   = 1'b0;
        lightseq = LS_RED;
        step(8);
        check("t1_cooldown_start", start, 0);
        step(5);
        check("t1_idle_start", start, 0);
        check("t1_idle_pending", pending, 0);

        // Short glitches never register
        for (int w = 1; w <= 3; w++) begin
            button = 1'b1;
            step(w);
            button = 1'b0;
            step(10);
            check("glitch_start", start, 0);
            check("glitch_wait_lamp", wait_lamp, 0);
        end

        // Second press during SERVING is queued and issued after cooldown
        button = 1'b1;
        exp_q.push_back(cyc + 7);
        step(7);
        check("t3_start", start, 1);
        button = 1'b0;
        step(1);
        lightseq = LS_GREEN;
        step(1);
        check("t3_serving_start", start, 0);
        step(8);
        button = 1'b1;
        step(7);
        check("t3_pending", pending, 1);
        check("t3_pending_lamp", wait_lamp, 1);
        check("t3_pending_start", start, 0);
        button   = 1'b0;
        lightseq = LS_RED;
        exp_q.push_back(cyc + 9);
        step(8);
        check("t3_cooldown_start", start, 0);
        check("t3_cooldown_pending", pending, 1);
        check("t3_cooldown_lamp", wait_lamp, 1);
        step(1);
        check("t3_reissue_start", start, 1);
        check("t3_reissue_pending", pending, 0);
        check("t3_reissue_lamp", wait_lamp, 1);
        lightseq = LS_GREEN;
        step(1);
        lightseq = LS_RED;
        step(12);
        check("t3_idle_start", start, 0);

        // Timeout: green withheld
        button = 1'b1;
        exp_q.push_back(cyc + 7);
        step(7);
        button = 1'b0;
        check("t4_start", start, 1);
        step(254);
        check("t4_fault_early", fault, 0);
        step(1);
        check("t4_fault", fault, 1);
        check("t4_start_held", start, 1);
        step(40);
        check("t4_fault_sticky", fault, 1);
        check("t4_start_still", start, 1);
        lightseq = LS_GREEN;
        step(1);
        check("t4_served_start", start, 0);
        check("t4_served_fault", fault, 1);
        lightseq = LS_RED;
        step(12);
        check("t4_idle_fault", fault, 1);

        // Asynchronous reset in WAITING
        button = 1'b1;
        exp_q.push_back(cyc + 7);
        step(7);
        button = 1'b0;
        step(3);
        check("t5w_start", start, 1);
        #2 reset = 1'b0;
        #1;
        check("t5w_rst_start", start, 0);
        check("t5w_rst_wait_lamp", wait_lamp, 0);
        check("t5w_rst_fault", fault, 0);
        step(1);
        reset = 1'b1;
        step(20);
        check("t5w_after_start", start, 0);

        // Asynchronous reset in COOLDOWN with a queued request
        button = 1'b1;
        exp_q.push_back(cyc + 7);
        step(7);
        button = 1'b0;
        step(8);
        lightseq = LS_GREEN;
        step(1);
        button = 1'b1;
        step(7);
        button   = 1'b0;
        lightseq = LS_RED;
        step(4);
        check("t5c_pending", pending, 1);
        #2 reset = 1'b0;
        #1;
        check("t5c_rst_start", start, 0);
        check("t5c_rst_wait_lamp", wait_lamp, 0);
        check("t5c_rst_pending", pending, 0);
        step(1);
        reset = 1'b1;
        step(20);
        check("t5c_after_start", start, 0);
        check("t5c_after_pending", pending, 0);

        // Button held across reset release counts as a fresh press
        reset  = 1'b0;
        button = 1'b1;
        step(3);
        reset = 1'b1;
        exp_q.push_back(cyc + 7);
        step(6);
        check("t6_start_before", start, 0);
        step(1);
        check("t6_start", start, 1);
        button = 1'b0;
        lightseq = LS_GREEN;
        step(1);
        check("t6_served", start, 0);
        lightseq = LS_RED;
        step(12);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
